// File: rtl/beehive_noc_msg_framer.sv
// NoC message framer: emits a header flit, then metadata and payload flits, on one val/rdy channel.
// The declared length is authoritative; short payloads are zero-padded, long ones are drained.
module beehive_noc_msg_framer #(
   parameter int NOC_DATA_W = 512,
   parameter int CHIPID_W   = 14,
   parameter int XY_W       = 8,
   parameter int FBITS_W    = 4,
   parameter int MSG_LEN_W  = 22,
   parameter int MSG_TYPE_W = 8,
   parameter int META_W     = 8,
   parameter int BYTES_W    = 16,
   parameter int unsigned SRC_CHIPID = 0,
   parameter int unsigned SRC_X      = 0,
   parameter int unsigned SRC_Y      = 0,
   parameter int unsigned SRC_FBITS  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hdr_val,
   output logic                  hdr_rdy,
   input  logic [CHIPID_W-1:0]   hdr_dst_chip_id,
   input  logic [XY_W-1:0]       hdr_dst_x,
   input  logic [XY_W-1:0]       hdr_dst_y,
   input  logic [FBITS_W-1:0]    hdr_dst_fbits,
   input  logic [MSG_TYPE_W-1:0] hdr_msg_type,
   input  logic [META_W-1:0]     hdr_meta_flits,
   input  logic [BYTES_W-1:0]    hdr_data_bytes,
   input  logic                  meta_val,
   output logic                  meta_rdy,
   input  logic [NOC_DATA_W-1:0] meta_data,
   input  logic                  data_val,
   output logic                  data_rdy,
   input  logic [NOC_DATA_W-1:0] data_data,
   input  logic                  data_last,
   output logic                  noc_val,
   input  logic                  noc_rdy,
   output logic [NOC_DATA_W-1:0] noc_data,
   output logic                  err_len,
   input  logic                  err_clr
);

   localparam int BPF      = NOC_DATA_W / 8;
   localparam int LOG2_BPF = $clog2(BPF);
   localparam int DCNT_W   = BYTES_W + 1;
   localparam int HDR_W    = 2*CHIPID_W + 4*XY_W + 2*FBITS_W + MSG_LEN_W + MSG_TYPE_W + META_W;

   localparam logic [CHIPID_W-1:0] SRC_CHIPID_C = SRC_CHIPID[CHIPID_W-1:0];
   localparam logic [XY_W-1:0]     SRC_X_C      = SRC_X[XY_W-1:0];
   localparam logic [XY_W-1:0]     SRC_Y_C      = SRC_Y[XY_W-1:0];
   localparam logic [FBITS_W-1:0]  SRC_FBITS_C  = SRC_FBITS[FBITS_W-1:0];

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      META  = 3'd2,
      DATA  = 3'd3,
      PAD   = 3'd4,
      DRAIN = 3'd5
   } state_t;

   state_t                state_r;
   logic [NOC_DATA_W-1:0] hdr_r;
   logic [META_W-1:0]     meta_cnt_r;
   logic [DCNT_W-1:0]     data_cnt_r;
   logic                  err_len_r;

   logic [DCNT_W-1:0]     dflits_s;
   logic [MSG_LEN_W-1:0]  msg_len_s;
   logic                  hdr_rdy_s;
   logic                  meta_rdy_s;
   logic                  data_rdy_s;
   logic                  noc_val_s;
   logic [NOC_DATA_W-1:0] noc_data_s;
   logic                  err_set_s;

   function automatic logic [DCNT_W-1:0] calc_dflits(input logic [BYTES_W-1:0] bytes);
      logic [DCNT_W-1:0] sum;
      sum = DCNT_W'(bytes) + DCNT_W'(BPF - 1);
      return sum >> LOG2_BPF;
   endfunction

   function automatic logic [NOC_DATA_W-1:0] build_header(
      input logic [CHIPID_W-1:0]   chip,
      input logic [XY_W-1:0]       x,
      input logic [XY_W-1:0]       y,
      input logic [FBITS_W-1:0]    fbits,
      input logic [MSG_LEN_W-1:0]  len,
      input logic [MSG_TYPE_W-1:0] mtype,
      input logic [META_W-1:0]     meta
   );
      logic [HDR_W-1:0] fields;
      fields = {chip, x, y, fbits, len, mtype,
                SRC_CHIPID_C, SRC_X_C, SRC_Y_C, SRC_FBITS_C, meta};
      return NOC_DATA_W'(fields) << (NOC_DATA_W - HDR_W);
   endfunction

   assign dflits_s  = calc_dflits(hdr_data_bytes);
   assign msg_len_s = MSG_LEN_W'(hdr_meta_flits) + MSG_LEN_W'(dflits_s);

   // Handshake and output steering; everything is held quiet while reset is asserted
   always_comb begin
      hdr_rdy_s  = 1'b0;
      meta_rdy_s = 1'b0;
      data_rdy_s = 1'b0;
      noc_val_s  = 1'b0;
      noc_data_s = {NOC_DATA_W{1'b0}};
      err_set_s  = 1'b0;
      if (rst_n) begin
         case (state_r)
            IDLE: hdr_rdy_s = 1'b1;
            HDR: begin
               noc_val_s  = 1'b1;
               noc_data_s = hdr_r;
            end
            META: begin
               noc_val_s  = meta_val;
               noc_data_s = meta_data;
               meta_rdy_s = noc_rdy;
            end
            DATA: begin
               noc_val_s  = data_val;
               noc_data_s = data_data;
               data_rdy_s = noc_rdy;
               if (data_val && noc_rdy) begin
                  err_set_s = (data_cnt_r == DCNT_W'(1)) ? !data_last : data_last;
               end else begin
                  err_set_s = 1'b0;
               end
            end
            PAD:     noc_val_s  = 1'b1;
            DRAIN:   data_rdy_s = 1'b1;
            default: noc_val_s  = 1'b0;
         endcase
      end else begin
         hdr_rdy_s = 1'b0;
      end
   end

   // Message FSM and flit counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         hdr_r      <= {NOC_DATA_W{1'b0}};
         meta_cnt_r <= {META_W{1'b0}};
         data_cnt_r <= {DCNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (hdr_val) begin
                  hdr_r      <= build_header(hdr_dst_chip_id, hdr_dst_x, hdr_dst_y, hdr_dst_fbits,
                                             msg_len_s, hdr_msg_type, hdr_meta_flits);
                  meta_cnt_r <= hdr_meta_flits;
                  data_cnt_r <= dflits_s;
                  state_r    <= HDR;
               end
            end
            HDR: begin
               if (noc_rdy) begin
                  if (meta_cnt_r != {META_W{1'b0}})      state_r <= META;
                  else if (data_cnt_r != {DCNT_W{1'b0}}) state_r <= DATA;
                  else                                   state_r <= IDLE;
               end
            end
            META: begin
               if (meta_val && noc_rdy) begin
                  meta_cnt_r <= meta_cnt_r - META_W'(1);
                  if (meta_cnt_r == META_W'(1)) begin
                     state_r <= (data_cnt_r != {DCNT_W{1'b0}}) ? DATA : IDLE;
                  end
               end
            end
            DATA: begin
               if (data_val && noc_rdy) begin
                  data_cnt_r <= data_cnt_r - DCNT_W'(1);
                  if (data_cnt_r == DCNT_W'(1)) state_r <= data_last ? IDLE : DRAIN;
                  else if (data_last)           state_r <= PAD;
               end
            end
            PAD: begin
               if (noc_rdy) begin
                  data_cnt_r <= data_cnt_r - DCNT_W'(1);
                  if (data_cnt_r == DCNT_W'(1)) state_r <= IDLE;
               end
            end
            DRAIN: begin
               if (data_val && data_last) state_r <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Sticky length-mismatch flag; a new mismatch beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!rst_n)         err_len_r <= 1'b0;
      else if (err_set_s) err_len_r <= 1'b1;
      else if (err_clr)   err_len_r <= 1'b0;
      else                err_len_r <= err_len_r;
   end

   assign hdr_rdy  = hdr_rdy_s;
   assign meta_rdy = meta_rdy_s;
   assign data_rdy = data_rdy_s;
   assign noc_val  = noc_val_s;
   assign noc_data = noc_data_s;
   assign err_len  = err_len_r;

endmodule
